// File: rtl/cpu_types_pkg.sv
// Shared word/tag types and constants for the front-end pipeline control registers.
package cpu_types_pkg;
  localparam int WBITS = 32;
  typedef logic [WBITS-1:0] word_t;
  typedef word_t tag_t;
  localparam word_t NOP_INSTR = 32'h0000_0000;
  localparam tag_t  TAG_NONE  = 32'h0000_0000;

  function automatic word_t next_word(input word_t addr);
    return addr + 32'd4;
  endfunction
endpackage

// File: rtl/pipe_ctrl_if.sv
// Stall/flush controls from the hazard unit and the control-flow tag chain fed back to it.
interface pipe_ctrl_if;
  import cpu_types_pkg::*;
  logic stall_PC;
  logic stall_IFID;
  logic flush_IFID;
  logic flush_IDEX;
  tag_t tmpPC;
  tag_t IDEX_tmpPC;
  tag_t EXMEM_tmpPC;

  modport pc (
    input  stall_PC, stall_IFID, flush_IFID, flush_IDEX,
    output tmpPC, IDEX_tmpPC, EXMEM_tmpPC
  );
  modport hu (
    input  tmpPC, IDEX_tmpPC, EXMEM_tmpPC,
    output stall_PC, stall_IFID, flush_IFID, flush_IDEX
  );
endinterface

// File: rtl/pc_reg.sv
// Program counter with stall/redirect/increment next-PC selection and the icache read enable.
module pc_reg
  import cpu_types_pkg::*;
#(
  parameter word_t PC_INIT = 32'h0000_0000
) (
  input  logic        CLK,
  input  logic        nRST,
  input  logic        pipe_en,
  input  logic        take_EXMEM,
  input  word_t       target_EXMEM,
  pipe_ctrl_if.pc     ctrl,
  output word_t       imemaddr,
  output word_t       pc_plus4,
  output logic        imemREN
);
  word_t pc_r;
  word_t pc_next;

  assign pc_plus4 = next_word(pc_r);
  assign imemaddr = pc_r;
  assign imemREN  = nRST;

  // A zero EX/MEM tag means no control instruction, so take_EXMEM is ignored then.
  always_comb begin
    pc_next = pc_r;
    if (ctrl.stall_PC) begin
      pc_next = pc_r;
    end else if ((ctrl.EXMEM_tmpPC != TAG_NONE) && take_EXMEM) begin
      pc_next = target_EXMEM;
    end else begin
      pc_next = pc_plus4;
    end
  end

  always_ff @(posedge CLK) begin
    if (!nRST) begin
      pc_r <= PC_INIT;
    end else if (pipe_en) begin
      pc_r <= pc_next;
    end
  end
endmodule

// File: rtl/pipe_ctrl_regs.sv
// Front-end pipeline state: PC, IF/ID latch and the tmpPC -> IDEX -> EXMEM tag chain.
module pipe_ctrl_regs
  import cpu_types_pkg::*;
#(
  parameter word_t PC_INIT = 32'h0000_0000
) (
  input  logic        CLK,
  input  logic        nRST,
  input  logic        ihit,
  input  word_t       imemload,
  input  logic        ctrl_ID,
  input  logic        take_EXMEM,
  input  word_t       target_EXMEM,
  input  logic        stall_PC,
  input  logic        stall_IFID,
  input  logic        flush_IFID,
  input  logic        flush_IDEX,
  output word_t       imemaddr,
  output logic        imemREN,
  output word_t       instr_ID,
  output word_t       npc_ID,
  output tag_t        tmpPC,
  output tag_t        IDEX_tmpPC,
  output tag_t        EXMEM_tmpPC
);
  pipe_ctrl_if ctrl_if ();

  logic  pipe_en;
  word_t pc_plus4;
  word_t instr_r;
  word_t npc_r;
  tag_t  idex_tag_r;
  tag_t  exmem_tag_r;

  assign pipe_en            = ihit;
  assign ctrl_if.stall_PC   = stall_PC;
  assign ctrl_if.stall_IFID = stall_IFID;
  assign ctrl_if.flush_IFID = flush_IFID;
  assign ctrl_if.flush_IDEX = flush_IDEX;
  assign ctrl_if.tmpPC       = ctrl_ID ? npc_r : TAG_NONE;
  assign ctrl_if.IDEX_tmpPC  = idex_tag_r;
  assign ctrl_if.EXMEM_tmpPC = exmem_tag_r;

  pc_reg #(.PC_INIT(PC_INIT)) u_pc_reg (
    .CLK          (CLK),
    .nRST         (nRST),
    .pipe_en      (pipe_en),
    .take_EXMEM   (take_EXMEM),
    .target_EXMEM (target_EXMEM),
    .ctrl         (ctrl_if),
    .imemaddr     (imemaddr),
    .pc_plus4     (pc_plus4),
    .imemREN      (imemREN)
  );

  // Flush beats stall on IF/ID; with ihit low nothing moves, flushes included.
  always_ff @(posedge CLK) begin
    if (!nRST) begin
      instr_r     <= NOP_INSTR;
      npc_r       <= 32'h0000_0000;
      idex_tag_r  <= TAG_NONE;
      exmem_tag_r <= TAG_NONE;
    end else if (pipe_en) begin
      if (ctrl_if.flush_IFID) begin
        instr_r <= NOP_INSTR;
        npc_r   <= 32'h0000_0000;
      end else if (!ctrl_if.stall_IFID) begin
        instr_r <= imemload;
        npc_r   <= pc_plus4;
      end
      idex_tag_r  <= ctrl_if.flush_IDEX ? TAG_NONE : ctrl_if.tmpPC;
      exmem_tag_r <= idex_tag_r;
    end
  end

  assign instr_ID    = instr_r;
  assign npc_ID      = npc_r;
  assign tmpPC       = ctrl_if.tmpPC;
  assign IDEX_tmpPC  = ctrl_if.IDEX_tmpPC;
  assign EXMEM_tmpPC = ctrl_if.EXMEM_tmpPC;
endmodule

// File: tb/tb_pipe_ctrl_regs.sv
// Directed bench for pipe_ctrl_regs: reset, straight line, taken/not-taken branches, ihit gating, reset mid-branch.
module tb_pipe_ctrl_regs;
  logic        CLK = 1'b0;
  logic        nRST, ihit, ctrl_ID, take_EXMEM;
  logic        stall_PC, stall_IFID, flush_IFID, flush_IDEX;
  logic [31:0] imemload, target_EXMEM;
  logic [31:0] imemaddr, instr_ID, npc_ID, tmpPC, IDEX_tmpPC, EXMEM_tmpPC;
  logic        imemREN;
  int          passed = 0;
  int          total  = 0;

  pipe_ctrl_regs #(.PC_INIT(32'h0000_0000)) dut (
    .CLK(CLK), .nRST(nRST), .ihit(ihit), .imemload(imemload), .ctrl_ID(ctrl_ID),
    .take_EXMEM(take_EXMEM), .target_EXMEM(target_EXMEM), .stall_PC(stall_PC),
    .stall_IFID(stall_IFID), .flush_IFID(flush_IFID), .flush_IDEX(flush_IDEX),
    .imemaddr(imemaddr), .imemREN(imemREN), .instr_ID(instr_ID), .npc_ID(npc_ID),
    .tmpPC(tmpPC), .IDEX_tmpPC(IDEX_tmpPC), .EXMEM_tmpPC(EXMEM_tmpPC)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic ctl(input logic s_pc, input logic s_ifid, input logic f_ifid, input logic f_idex);
    stall_PC = s_pc; stall_IFID = s_ifid; flush_IFID = f_ifid; flush_IDEX = f_idex;
  endtask

  initial begin
    nRST = 1'b0; ihit = 1'b0; ctrl_ID = 1'b0; take_EXMEM = 1'b0;
    imemload = 32'h0; target_EXMEM = 32'h0; ctl(1'b0, 1'b0, 1'b0, 1'b0);

    // reset held two cycles
    step(); step();
    chk("rst_pc", imemaddr, 32'h0);
    chk("rst_ren", {31'd0, imemREN}, 32'd0);
    chk("rst_instr", instr_ID, 32'h0);
    chk("rst_npc", npc_ID, 32'h0);
    chk("rst_idex", IDEX_tmpPC, 32'h0);
    chk("rst_exmem", EXMEM_tmpPC, 32'h0);
    nRST = 1'b1; #1;
    chk("ren_on", {31'd0, imemREN}, 32'd1);

    // straight line at PC 0,4,8,C
    ihit = 1'b1; imemload = 32'hA000_0000; step();
    chk("sl0_pc", imemaddr, 32'h4); chk("sl0_instr", instr_ID, 32'hA000_0000); chk("sl0_npc", npc_ID, 32'h4);
    imemload = 32'hA000_0001; step();
    chk("sl1_pc", imemaddr, 32'h8); chk("sl1_instr", instr_ID, 32'hA000_0001); chk("sl1_npc", npc_ID, 32'h8);
    // take_EXMEM with a zero EX/MEM tag must not redirect
    imemload = 32'hA000_0002; take_EXMEM = 1'b1; target_EXMEM = 32'h80; step();
    chk("sl2_pc_noredir", imemaddr, 32'hC); chk("sl2_npc", npc_ID, 32'hC);
    chk("sl2_idex", IDEX_tmpPC, 32'h0); chk("sl2_exmem", EXMEM_tmpPC, 32'h0);
    take_EXMEM = 1'b0; imemload = 32'hA000_0003; step();
    chk("sl3_pc", imemaddr, 32'h10);
    imemload = 32'hB000_0000; step();
    chk("br_in_id", instr_ID, 32'hB000_0000); chk("br_npc", npc_ID, 32'h14);

    // taken branch at 0x10, t
    ctrl_ID = 1'b1; ctl(1'b1, 1'b0, 1'b0, 1'b0); imemload = 32'hA000_0005; #1;
    chk("tk_t_tmp", tmpPC, 32'h14);
    step();
    ctrl_ID = 1'b0; ctl(1'b1, 1'b1, 1'b0, 1'b1); #1;
    chk("tk_t1_idex", IDEX_tmpPC, 32'h14); chk("tk_t1_pc", imemaddr, 32'h14);
    chk("tk_t1_tmp", tmpPC, 32'h0);
    step();
    chk("tk_t2_exmem", EXMEM_tmpPC, 32'h14); chk("tk_t2_idex_bub", IDEX_tmpPC, 32'h0);
    // flush and stall together: flush wins
    ctl(1'b0, 1'b1, 1'b1, 1'b0); take_EXMEM = 1'b1; target_EXMEM = 32'h40; step();
    chk("tk_pc", imemaddr, 32'h40); chk("tk_instr_flush", instr_ID, 32'h0);
    chk("tk_npc_flush", npc_ID, 32'h0); chk("tk_idex", IDEX_tmpPC, 32'h0);

    // not-taken branch at 0x40
    take_EXMEM = 1'b0; ctl(1'b0, 1'b0, 1'b0, 1'b0); imemload = 32'hB000_0001; step();
    chk("nt_pc", imemaddr, 32'h44);
    ctrl_ID = 1'b1; ctl(1'b1, 1'b0, 1'b0, 1'b0); imemload = 32'hC000_0001; #1;
    chk("nt_t_tmp", tmpPC, 32'h44);
    step();
    ctrl_ID = 1'b0; ctl(1'b1, 1'b1, 1'b0, 1'b1); step();
    chk("nt_t2_exmem", EXMEM_tmpPC, 32'h44); chk("nt_t2_pc", imemaddr, 32'h44);
    ctl(1'b0, 1'b1, 1'b0, 1'b0); target_EXMEM = 32'h200; step();
    chk("nt_pc_inc", imemaddr, 32'h48); chk("nt_instr_hold", instr_ID, 32'hC000_0001);
    chk("nt_npc_hold", npc_ID, 32'h48);

    // branch at 0x44, then icache miss for 3 cycles
    ctrl_ID = 1'b1; ctl(1'b1, 1'b0, 1'b0, 1'b0); imemload = 32'hD000_0000; step();
    chk("ih_idex", IDEX_tmpPC, 32'h48);
    ihit = 1'b0; ctrl_ID = 1'b0; ctl(1'b1, 1'b1, 1'b1, 1'b1);
    take_EXMEM = 1'b1; target_EXMEM = 32'h100; imemload = 32'hEEEE_EEEE;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("ih_pc", imemaddr, 32'h48); chk("ih_instr", instr_ID, 32'hD000_0000);
      chk("ih_npc", npc_ID, 32'h4C); chk("ih_idex", IDEX_tmpPC, 32'h48);
      chk("ih_exmem", EXMEM_tmpPC, 32'h0);
    end
    ihit = 1'b1; take_EXMEM = 1'b0; ctl(1'b1, 1'b1, 1'b0, 1'b1); step();
    chk("res_exmem", EXMEM_tmpPC, 32'h48); chk("res_idex", IDEX_tmpPC, 32'h0);
    chk("res_instr", instr_ID, 32'hD000_0000);
    take_EXMEM = 1'b1; ctl(1'b0, 1'b0, 1'b1, 1'b0); step();
    chk("res_pc", imemaddr, 32'h100); chk("res_flush", instr_ID, 32'h0);

    // reset asserted at t+1 of a branch
    take_EXMEM = 1'b0; ctl(1'b0, 1'b0, 1'b0, 1'b0); imemload = 32'hE000_0000; step();
    ctrl_ID = 1'b1; ctl(1'b1, 1'b0, 1'b0, 1'b0); imemload = 32'hE000_0001; step();
    chk("rb_idex", IDEX_tmpPC, 32'h104);
    ctrl_ID = 1'b0; ctl(1'b1, 1'b1, 1'b0, 1'b1); nRST = 1'b0; take_EXMEM = 1'b1; target_EXMEM = 32'h300;
    step();
    chk("rb_pc", imemaddr, 32'h0); chk("rb_idex0", IDEX_tmpPC, 32'h0);
    chk("rb_exmem0", EXMEM_tmpPC, 32'h0); chk("rb_instr", instr_ID, 32'h0);
    chk("rb_ren", {31'd0, imemREN}, 32'd0);
    nRST = 1'b1; ctl(1'b0, 1'b0, 1'b0, 1'b0); step();
    chk("rb_noredir", imemaddr, 32'h4); chk("rb_exmem1", EXMEM_tmpPC, 32'h0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
